cursor_move_scheduler: RTL

//  Sequences the two grid cursors (A, B) on the 8x8 field from the shared button event stream.

---
 rtl/cursor_move_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cursor_move_scheduler.sv
// cursor_move_scheduler: latches button moves for cursors A/B, grants them round-robin, applies bounds/collision, publishes over valid/ready.
// Define CURSOR_WRAP_EN to wrap edge moves within their row/column instead of rejecting them.
module cursor_move_scheduler #(
  parameter logic [5:0]  A_INIT = 6'd9,
  parameter logic [5:0]  B_INIT = 6'd14,
  parameter logic [31:0] A_KEYS = {8'd8, 8'd10, 8'd1, 8'd9},
  parameter logic [31:0] B_KEYS = {8'd11, 8'd13, 8'd4, 8'd12}
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_pressed,
  input  logic [7:0] button_index,
  output logic [7:0] a_index,
  output logic [7:0] b_index,
  output logic       upd_valid,
  input  logic       upd_ready,
  output logic       upd_player,
  output logic [5:0] upd_old,
  output logic [5:0] upd_new,
  output logic       busy,
  output logic [7:0] rej_cnt,
  output logic [7:0] drop_cnt
);
  typedef enum logic [1:0] {IDLE, EVAL, EMIT} state_t;
  state_t state;
  logic [5:0] a_pos, b_pos, own, other, target;
  logic [2:0] row, col;
  logic [1:0] dir_a, dir_b, cur_dir, key_dir;
  logic pressed_q, pend_a, pend_b, last_grant, cur_player;
  logic hit_a, hit_b, set_a, set_b, grant, sel, oob, reject, drop;
  assign a_index = {2'b00, a_pos};
  assign b_index = {2'b00, b_pos};
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    key_dir = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (button_index == A_KEYS[31-8*i -: 8]) begin
        hit_a = 1'b1;
        key_dir = 2'(i);
      end
      if (button_index == B_KEYS[31-8*i -: 8]) begin
        hit_b = 1'b1;
        key_dir = 2'(i);
      end
    end
  end
  assign set_a = button_pressed & ~pressed_q & hit_a;
  assign set_b = button_pressed & ~pressed_q & hit_b;
  assign grant = (state == IDLE) & (pend_a | pend_b);
  assign sel = pend_b & (~pend_a | ~last_grant);
  // a pend being granted this edge is consumed, not overwritten
  assign drop = (set_a & pend_a & ~(grant & ~sel)) | (set_b & pend_b & ~(grant & sel));
  assign own = cur_player ? b_pos : a_pos;
  assign other = cur_player ? a_pos : b_pos;
  assign row = own[5:3];
  assign col = own[2:0];
  assign target = cur_dir == 2'd0 ? {row, col - 3'd1} :
                  cur_dir == 2'd1 ? {row, col + 3'd1} :
                  cur_dir == 2'd2 ? {row - 3'd1, col} : {row + 3'd1, col};
`ifdef CURSOR_WRAP_EN
  assign oob = 1'b0;
`else
  assign oob = cur_dir == 2'd0 ? col == 3'd0 :
               cur_dir == 2'd1 ? col == 3'd7 :
               cur_dir == 2'd2 ? row == 3'd0 : row == 3'd7;
`endif
  assign reject = oob | (target == other);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_pos <= A_INIT;
      b_pos <= B_INIT;
      pressed_q <= 1'b0;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      dir_a <= 2'd0;
      dir_b <= 2'd0;
      cur_dir <= 2'd0;
      cur_player <= 1'b0;
      last_grant <= 1'b1;
      upd_valid <= 1'b0;
      upd_player <= 1'b0;
      upd_old <= 6'd0;
      upd_new <= 6'd0;
      busy <= 1'b0;
      rej_cnt <= 8'd0;
      drop_cnt <= 8'd0;
    end else begin
      pressed_q <= button_pressed;
      case (state)
        IDLE: if (grant) begin
          cur_player <= sel;
          cur_dir <= sel ? dir_b : dir_a;
          last_grant <= sel;
          if (sel) pend_b <= 1'b0;
          else pend_a <= 1'b0;
          busy <= 1'b1;
          state <= EVAL;
        end
        EVAL: if (reject) begin
          rej_cnt <= rej_cnt + {7'd0, rej_cnt != 8'hff};
          busy <= 1'b0;
          state <= IDLE;
        end else begin
          if (cur_player) b_pos <= target;
          else a_pos <= target;
          upd_player <= cur_player;
          upd_old <= own;
          upd_new <= target;
          upd_valid <= 1'b1;
          state <= EMIT;
        end
        EMIT: if (upd_ready) begin
          upd_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // new presses override a same-edge grant clear
      if (set_a) begin
        pend_a <= 1'b1;
        dir_a <= key_dir;
      end
      if (set_b) begin
        pend_b <= 1'b1;
        dir_b <= key_dir;
      end
      if (drop) drop_cnt <= drop_cnt + {7'd0, drop_cnt != 8'hff};
    end
  end
endmodule
